// File: rtl/rtc_pkg.sv
// Stopwatch control types shared by the trigger controller and the display/latch blocks.
// The state encoding is visible on o_state, so downstream LED decode relies on these values.
package rtc_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      COUNTING = 2'b01,
      PAUSE    = 2'b10,
      LAP      = 2'b11
   } state_t;

   typedef struct packed {
      logic count_init;
      logic count_enb;
      logic latch_count;
   } ctrl_t;

   // Moore decode of the datapath controls; unreachable encodings fall back to IDLE controls.
   function automatic ctrl_t decode_ctrl(input state_t s);
      ctrl_t c;
      case (s)
         IDLE:     c = '{count_init: 1'b1, count_enb: 1'b0, latch_count: 1'b0};
         COUNTING: c = '{count_init: 1'b0, count_enb: 1'b1, latch_count: 1'b0};
         LAP:      c = '{count_init: 1'b0, count_enb: 1'b1, latch_count: 1'b1};
         PAUSE:    c = '{count_init: 1'b0, count_enb: 1'b0, latch_count: 1'b1};
         default:  c = '{count_init: 1'b1, count_enb: 1'b0, latch_count: 1'b0};
      endcase
      return c;
   endfunction

endpackage

// File: rtl/rtc_debounce.sv
// Single-button debouncer: level accepted after BOUND+1 matching samples (BOUND+1 clks after first
// sample), one-clock rise pulse one clk later. No backpressure; any bounce restarts the window.
module rtc_debounce #(
   parameter int BOUND = 1_000_000,
   parameter int W     = $clog2(BOUND + 1)
) (
   input  logic i_sclk,
   input  logic i_reset_n,
   input  logic i_raw,
   output logic o_db,
   output logic o_rise
);

   logic         prv;
   logic         db_q;
   logic [W-1:0] cnt;

   always_ff @(posedge i_sclk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         prv    <= 1'b0;
         cnt    <= '0;
         o_db   <= 1'b0;
         db_q   <= 1'b0;
         o_rise <= 1'b0;
      end else begin
         prv <= i_raw;
         // Counter saturates so a long stable level never re-opens the window.
         if (i_raw != prv) begin
            cnt <= '0;
         end else if (cnt != W'(BOUND)) begin
            cnt <= cnt + W'(1);
         end
         if ((i_raw == prv) && (cnt == W'(BOUND))) begin
            o_db <= i_raw;
         end
         db_q   <= o_db;
         o_rise <= o_db & ~db_q;
      end
   end

endmodule

// File: rtl/rtc_trigger_ctrl.sv
// Stopwatch front-end: two debounced buttons drive a Moore FSM controlling the RTC counter/latch.
// Button edge to output change is DB_BOUND+3 clks; lap held LONG_CYCLES clks in PAUSE clears to IDLE.
module rtc_trigger_ctrl
   import rtc_pkg::*;
#(
   parameter int DB_BOUND    = 1_000_000,
   parameter int LONG_CYCLES = 50_000_000
) (
   input  logic       i_sclk,
   input  logic       i_reset_n,
   input  logic       i_trigger,
   input  logic       i_lap,
   output logic       o_count_init,
   output logic       o_count_enb,
   output logic       o_latch_count,
   output logic [1:0] o_state
);

   localparam int DB_W   = $clog2(DB_BOUND + 1);
   localparam int LONG_W = $clog2(LONG_CYCLES + 1);

   state_t              cur;
   state_t              nxt;
   logic                trig_lvl_unused;
   logic                trig_rise;
   logic                lap_db;
   logic                lap_rise;
   logic [LONG_W-1:0]   hold_cnt;
   logic                hold_qual;
   logic                clear;
   ctrl_t               ctrl;

   rtc_debounce #(.BOUND(DB_BOUND), .W(DB_W)) u_trig (
      .i_sclk    (i_sclk),
      .i_reset_n (i_reset_n),
      .i_raw     (i_trigger),
      .o_db      (trig_lvl_unused),
      .o_rise    (trig_rise)
   );

   rtc_debounce #(.BOUND(DB_BOUND), .W(DB_W)) u_lap (
      .i_sclk    (i_sclk),
      .i_reset_n (i_reset_n),
      .i_raw     (i_lap),
      .o_db      (lap_db),
      .o_rise    (lap_rise)
   );

   // Hold counter only runs while paused, so lap held across entry into PAUSE counts from entry.
   assign hold_qual = (cur == PAUSE) && lap_db;
   assign clear     = hold_qual && (hold_cnt == LONG_W'(LONG_CYCLES - 1));

   always_ff @(posedge i_sclk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         hold_cnt <= '0;
      end else if (!hold_qual) begin
         hold_cnt <= '0;
      end else if (hold_cnt != LONG_W'(LONG_CYCLES)) begin
         hold_cnt <= hold_cnt + LONG_W'(1);
      end
   end

   always_ff @(posedge i_sclk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         cur <= IDLE;
      end else begin
         cur <= nxt;
      end
   end

   // Trigger is tested first in every state so it wins over a same-clock lap press or clear.
   always_comb begin
      nxt = cur;
      case (cur)
         IDLE: begin
            if (trig_rise) nxt = COUNTING;
         end
         COUNTING: begin
            if (trig_rise)     nxt = PAUSE;
            else if (lap_rise) nxt = LAP;
         end
         LAP: begin
            if (trig_rise)     nxt = PAUSE;
            else if (lap_rise) nxt = COUNTING;
         end
         PAUSE: begin
            if (trig_rise)  nxt = COUNTING;
            else if (clear) nxt = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   assign ctrl          = decode_ctrl(cur);
   assign o_count_init  = ctrl.count_init;
   assign o_count_enb   = ctrl.count_enb;
   assign o_latch_count = ctrl.latch_count;
   assign o_state       = cur;

endmodule

// File: tb/tb_rtc_trigger_ctrl.sv
// Bench for rtc_trigger_ctrl with DB_BOUND=8, LONG_CYCLES=32: directed table, corner sequences,
// then random button activity compared against a sample-history reference model.
`timescale 1ns/1ps
module tb_rtc_trigger_ctrl;

   localparam int DB   = 8;
   localparam int LONG = 32;
   localparam logic [1:0] S_IDLE = 2'b00, S_CNT = 2'b01, S_PAUSE = 2'b10, S_LAP = 2'b11;

   logic       i_sclk    = 1'b0;
   logic       i_reset_n = 1'b0;
   logic       i_trigger = 1'b0;
   logic       i_lap     = 1'b0;
   logic       o_count_init, o_count_enb, o_latch_count;
   logic [1:0] o_state;

   int checks = 0;
   int errors = 0;

   rtc_trigger_ctrl #(.DB_BOUND(DB), .LONG_CYCLES(LONG)) dut (
      .i_sclk        (i_sclk),
      .i_reset_n     (i_reset_n),
      .i_trigger     (i_trigger),
      .i_lap         (i_lap),
      .o_count_init  (o_count_init),
      .o_count_enb   (o_count_enb),
      .o_latch_count (o_latch_count),
      .o_state       (o_state)
   );

   always #5 i_sclk = ~i_sclk;

   // Reference model: a button level is accepted once its last DB+2 samples agree.
   bit         rt_q[$];
   bit         rl_q[$];
   bit [2:0]   mdt, mdl;
   logic [1:0] m_state;
   int         m_run;

   typedef struct packed {
      logic       t;
      logic       l;
      logic [7:0] n;
      logic [1:0] st;
   } vec_t;
   vec_t vtab [0:15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_outs(input string name, input logic [1:0] st);
      chk({name, ".state"}, o_state, st);
      chk({name, ".init"}, o_count_init, st == S_IDLE);
      chk({name, ".enb"}, o_count_enb, (st == S_CNT) || (st == S_LAP));
      chk({name, ".latch"}, o_latch_count, (st == S_LAP) || (st == S_PAUSE));
   endtask

   function automatic bit all_same(input bit q[$]);
      foreach (q[i]) if (q[i] != q[0]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [1:0] ref_next(input logic [1:0] s, input bit rt, input bit rl, input bit clr);
      if (rt) return ((s == S_IDLE) || (s == S_PAUSE)) ? S_CNT : S_PAUSE;
      if (rl && (s == S_CNT)) return S_LAP;
      if (rl && (s == S_LAP)) return S_CNT;
      if (clr) return S_IDLE;
      return s;
   endfunction

   task automatic model_reset();
      rt_q = {};
      rl_q = {};
      for (int i = 0; i < DB + 2; i++) begin
         rt_q.push_back(1'b0);
         rl_q.push_back(1'b0);
      end
      mdt     = '0;
      mdl     = '0;
      m_state = S_IDLE;
      m_run   = 0;
   endtask

   // mdX[0] is the accepted level after the previous edge, [1] and [2] are older.
   task automatic model_edge(input bit t, input bit l);
      bit rise_t, rise_l, cond, clr, nt, nl;
      rise_t  = mdt[1] & ~mdt[2];
      rise_l  = mdl[1] & ~mdl[2];
      cond    = (m_state == S_PAUSE) && mdl[0];
      m_run   = cond ? m_run + 1 : 0;
      clr     = cond && (m_run == LONG);
      m_state = ref_next(m_state, rise_t, rise_l, clr);
      rt_q.push_back(t); void'(rt_q.pop_front());
      rl_q.push_back(l); void'(rl_q.pop_front());
      nt  = all_same(rt_q) ? t : mdt[0];
      nl  = all_same(rl_q) ? l : mdl[0];
      mdt = {mdt[1:0], nt};
      mdl = {mdl[1:0], nl};
   endtask

   task automatic tick(input bit t, input bit l);
      i_trigger = t;
      i_lap     = l;
      @(posedge i_sclk);
      model_edge(t, l);
      #1;
   endtask

   task automatic ticks(input bit t, input bit l, input int n);
      for (int i = 0; i < n; i++) tick(t, l);
   endtask

   task automatic do_reset(input string name);
      #2 i_reset_n = 1'b0;
      #1;
      chk_outs(name, S_IDLE);
      chk({name, ".trig_cnt"}, dut.u_trig.cnt, 0);
      chk({name, ".lap_cnt"}, dut.u_lap.cnt, 0);
      i_trigger = 1'b0;
      i_lap     = 1'b0;
      repeat (2) @(posedge i_sclk);
      #3 i_reset_n = 1'b1;
      model_reset();
   endtask

   initial begin
      bit rise_seen;
      int min_cnt;
      int rem_t, rem_l;
      bit lt, ll;

      model_reset();

      // Reset held from time zero.
      #3;
      chk_outs("reset0", S_IDLE);
      chk("reset0.trig_cnt", dut.u_trig.cnt, 0);
      repeat (3) @(posedge i_sclk);
      #3 i_reset_n = 1'b1;

      // Short bounces never produce a press.
      rise_seen = 1'b0;
      for (int i = 0; i < 26; i++) begin
         tick((i < 5) || (i >= 8 && i < 12), 1'b0);
         rise_seen |= dut.u_trig.o_rise;
      end
      chk("bounce.rise", rise_seen, 0);
      chk_outs("bounce", S_IDLE);

      // Clean press: level at E0+9, pulse at E0+10, state at E0+11.
      ticks(1'b1, 1'b0, 9);
      chk("press.db_early", dut.u_trig.o_db, 0);
      tick(1'b1, 1'b0);
      chk("press.db", dut.u_trig.o_db, 1);
      tick(1'b1, 1'b0);
      chk("press.rise", dut.u_trig.o_rise, 1);
      chk_outs("press.before", S_IDLE);
      tick(1'b1, 1'b0);
      chk_outs("press.after", S_CNT);
      min_cnt = 99;
      for (int i = 0; i < 8; i++) begin
         tick(1'b1, 1'b0);
         if (int'(dut.u_trig.cnt) < min_cnt) min_cnt = int'(dut.u_trig.cnt);
      end
      chk("press.cnt_sat", dut.u_trig.cnt, DB);
      chk("press.cnt_min", min_cnt, DB);
      ticks(1'b0, 1'b0, 14);
      chk_outs("press.release", S_CNT);

      // Reset arriving mid-debounce while counting.
      ticks(1'b1, 1'b0, 4);
      chk("middb.cnt", dut.u_trig.cnt, 3);
      chk("middb.lap_cnt", dut.u_lap.cnt, DB);
      do_reset("midrst");

      // Directed walk through every state transition and release.
      vtab[0]  = '{1'b1, 1'b0, 8'd14, S_CNT};
      vtab[1]  = '{1'b0, 1'b0, 8'd14, S_CNT};
      vtab[2]  = '{1'b0, 1'b1, 8'd14, S_LAP};
      vtab[3]  = '{1'b0, 1'b0, 8'd14, S_LAP};
      vtab[4]  = '{1'b0, 1'b1, 8'd14, S_CNT};
      vtab[5]  = '{1'b0, 1'b0, 8'd14, S_CNT};
      vtab[6]  = '{1'b0, 1'b1, 8'd14, S_LAP};
      vtab[7]  = '{1'b0, 1'b0, 8'd14, S_LAP};
      vtab[8]  = '{1'b1, 1'b0, 8'd14, S_PAUSE};
      vtab[9]  = '{1'b0, 1'b0, 8'd14, S_PAUSE};
      vtab[10] = '{1'b0, 1'b1, 8'd14, S_PAUSE};
      vtab[11] = '{1'b0, 1'b0, 8'd14, S_PAUSE};
      vtab[12] = '{1'b1, 1'b0, 8'd14, S_CNT};
      vtab[13] = '{1'b0, 1'b0, 8'd14, S_CNT};
      vtab[14] = '{1'b1, 1'b0, 8'd14, S_PAUSE};
      vtab[15] = '{1'b0, 1'b0, 8'd14, S_PAUSE};
      for (int v = 0; v < 16; v++) begin
         ticks(vtab[v].t, vtab[v].l, int'(vtab[v].n));
         chk_outs($sformatf("vec%0d", v), vtab[v].st);
      end

      // Long press: 20 held clks is not enough; the 32nd clears exactly once.
      ticks(1'b0, 1'b1, 30);
      chk_outs("long.short", S_PAUSE);
      ticks(1'b0, 1'b0, 14);
      chk_outs("long.rel", S_PAUSE);
      ticks(1'b0, 1'b1, 41);
      chk("long.hold31", dut.hold_cnt, LONG - 1);
      chk_outs("long.pre", S_PAUSE);
      tick(1'b0, 1'b1);
      chk_outs("long.clear", S_IDLE);
      rise_seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick(1'b0, 1'b1);
         if (o_state != S_IDLE) rise_seen = 1'b1;
      end
      chk("long.stay_idle", rise_seen, 0);
      ticks(1'b0, 1'b0, 14);

      // Trigger press landing on the clearing clock wins.
      ticks(1'b1, 1'b0, 14);
      ticks(1'b0, 1'b0, 14);
      ticks(1'b1, 1'b0, 14);
      ticks(1'b0, 1'b0, 14);
      chk_outs("race.pause", S_PAUSE);
      ticks(1'b0, 1'b1, 30);
      ticks(1'b1, 1'b1, 11);
      chk_outs("race.pre", S_PAUSE);
      tick(1'b1, 1'b1);
      chk_outs("race.win", S_CNT);
      tick(1'b1, 1'b1);
      chk("race.hold0", dut.hold_cnt, 0);
      ticks(1'b0, 1'b0, 14);
      chk_outs("race.settle", S_CNT);

      // Simultaneous presses: trigger has priority.
      ticks(1'b1, 1'b1, 14);
      chk_outs("simul.cnt", S_PAUSE);
      ticks(1'b0, 1'b0, 14);
      ticks(1'b1, 1'b1, 14);
      chk_outs("simul.pause", S_CNT);
      ticks(1'b0, 1'b0, 14);
      chk_outs("simul.rel", S_CNT);

      // Random button activity against the reference model.
      lt = 1'b0; ll = 1'b0; rem_t = 0; rem_l = 0;
      for (int i = 0; i < 4000; i++) begin
         if (rem_t == 0) begin
            lt    = ~lt;
            rem_t = int'($urandom_range(1, 30));
         end
         if (rem_l == 0) begin
            ll    = ~ll;
            rem_l = int'($urandom_range(1, 55));
         end
         rem_t--;
         rem_l--;
         tick(lt, ll);
         chk_outs("rand", m_state);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
